// File: rtl/axi_pkg.sv
// Shared AXI definitions: response codes, burst type, 4 KB page size and
// the write-master FSM state type.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } wr_state_t;

  function automatic logic [2:0] axi_size(input int unsigned data_w);
    logic [2:0] s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == data_w / 8) s = i[2:0];
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_w_skid.sv
// W-channel register slice: registered output plus one skid entry, so the
// upstream ready depends only on flop state, never on out_ready.
module axi_w_skid #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_strb,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_strb,
  output logic                out_last
);

  localparam int PW = DATA_W + DATA_W / 8 + 1;

  logic [PW-1:0] in_pay;
  logic [PW-1:0] out_q;
  logic [PW-1:0] skid_q;
  logic          skid_valid;

  assign in_pay   = {in_last, in_strb, in_data};
  assign {out_last, out_strb, out_data} = out_q;
  assign in_ready = !skid_valid;

  // A beat accepted while the output is stalled parks in the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_q <= in_pay;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_q     <= in_pay;
    end
  end

endmodule

// File: rtl/axi_burst_wr_master.sv
// Single-outstanding AXI INCR write-burst master: takes a burst command,
// streams user beats through a W skid stage and reports the B response.
module axi_burst_wr_master
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                done,
  output logic [1:0]          done_resp
);

  localparam int STRB_W = DATA_W / 8;

  wr_state_t      state, state_next;
  logic [LEN_W:0] beat_cnt;
  logic           ready_en;
  logic           cmd_fire;
  logic           cross_4k;
  logic [31:0]    burst_end;
  logic           beats_left;
  logic           skid_in_ready;
  logic           beat_fire;
  logic           last_fire;

  assign awsize     = axi_size(DATA_W);
  assign awburst    = BURST_INCR;
  assign cmd_ready  = ready_en && (state == ST_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign awvalid    = (state == ST_ADDR);
  assign bready     = (state == ST_RESP);
  assign beats_left = (beat_cnt <= {1'b0, awlen});
  assign wr_ready   = (state == ST_DATA) && beats_left && skid_in_ready;
  assign beat_fire  = wr_valid && wr_ready;
  assign last_fire  = wvalid && wready && wlast;

  always_comb begin
    burst_end = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_W);
    cross_4k  = (burst_end > 32'(BOUNDARY_4K));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_fire && !cross_4k) state_next = ST_ADDR;
      ST_ADDR: if (awready)               state_next = ST_DATA;
      ST_DATA: if (last_fire)             state_next = ST_RESP;
      ST_RESP: if (bvalid)                state_next = ST_IDLE;
      default:                            state_next = ST_IDLE;
    endcase
  end

  // ready_en keeps cmd_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en  <= 1'b0;
      awaddr    <= '0;
      awlen     <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
      done_resp <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      if (cmd_fire) begin
        if (cross_4k) begin
          done      <= 1'b1;
          done_resp <= RESP_SLVERR;
        end else begin
          awaddr   <= cmd_addr;
          awlen    <= cmd_len;
          beat_cnt <= '0;
        end
      end
      if (beat_fire) beat_cnt <= beat_cnt + 1'b1;
      if (state == ST_RESP && bvalid) begin
        done      <= 1'b1;
        done_resp <= bresp;
      end
    end
  end

  axi_w_skid #(
    .DATA_W (DATA_W)
  ) u_w_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (beat_fire),
    .in_ready  (skid_in_ready),
    .in_data   (wr_data),
    .in_strb   (wr_strb),
    .in_last   (beat_cnt == {1'b0, awlen}),
    .out_valid (wvalid),
    .out_ready (wready),
    .out_data  (wdata),
    .out_strb  (wstrb),
    .out_last  (wlast)
  );

endmodule

// File: tb/tb_axi_burst_wr_master.sv
// Scoreboard bench for axi_burst_wr_master: random commands, AXI slave with
// random backpressure, and a queue-based reference of expected AW/W/done.
module tb_axi_burst_wr_master;
  import axi_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        done;
  logic [1:0]  done_resp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int w_hs_total = 0;
  int wlast_cnt = 0;
  bit bp = 1'b0;
  bit b2b = 1'b0;

  aw_t        exp_aw[$];
  w_t         exp_w[$];
  logic [1:0] exp_done[$];
  logic [1:0] bresp_plan[$];

  axi_burst_wr_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .done      (done),
    .done_resp (done_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget (cycle %0d)", name, cyc);
  endtask

  // Monitor: stability of stalled channels and in-order scoreboard pops.
  logic        aw_stall = 1'b0, w_stall = 1'b0;
  logic [39:0] aw_prev;
  logic [36:0] w_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_stall = 1'b0;
      w_stall  = 1'b0;
    end else begin
      if (aw_stall) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, aw_prev});
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) timeout_fail("aw_unexpected");
        else begin
          aw_t a;
          a = exp_aw.pop_front();
          chk("awaddr", awaddr, a.addr);
          chk("awlen", awlen, a.len);
          chk("awsize", awsize, 3'd2);
          chk("awburst", awburst, 2'b01);
        end
      end
      aw_stall = awvalid && !awready;
      aw_prev  = {awaddr, awlen};

      if (w_stall) chk("w_stable", {wvalid, wlast, wstrb, wdata}, {1'b1, w_prev});
      if (wvalid && wready) begin
        if (exp_w.size() == 0) timeout_fail("w_unexpected");
        else begin
          w_t w;
          w = exp_w.pop_front();
          chk("wdata", wdata, w.data);
          chk("wstrb", wstrb, w.strb);
          chk("wlast", wlast, w.last);
        end
        w_hs_total++;
        if (wlast) wlast_cnt++;
      end
      w_stall = wvalid && !wready;
      w_prev  = {wlast, wstrb, wdata};

      if (done) begin
        if (exp_done.size() == 0) timeout_fail("done_unexpected");
        else chk("done_resp", done_resp, exp_done.pop_front());
        last_done_cyc = cyc;
      end
    end
  end

  // AXI slave: ready backpressure and one B response per completed burst.
  initial begin : slave
    int b_issued;
    bit b_hs;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = 2'b00;
    b_issued = 0;
    forever begin
      @(negedge clk);
      b_hs = bvalid && bready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        b_issued = wlast_cnt;
      end else begin
        awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        wready  = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (bvalid && b_hs) bvalid = 1'b0;
        if (!bvalid && wlast_cnt > b_issued && bresp_plan.size() > 0 &&
            (!bp || $urandom_range(0, 1) == 1)) begin
          bvalid = 1'b1;
          bresp  = bresp_plan.pop_front();
          b_issued++;
        end
      end
    end
  end

  task automatic run_cmd(input logic [31:0] addr, input int unsigned len,
                         input logic [1:0] resp, input logic [31:0] d0,
                         input int unsigned abort_after);
    bit rej;
    bit hs;
    bit acc;
    int budget;
    int start_w;
    int unsigned i;
    w_t beats[$];
    rej = ((addr % 4096) + (len + 1) * 4) > 4096;
    if (rej) exp_done.push_back(2'b10);
    else begin
      exp_aw.push_back('{addr: addr, len: 8'(len)});
      for (int unsigned k = 0; k <= len; k++) begin
        w_t b;
        b.data = (k == 0) ? d0 : $urandom;
        b.strb = 4'($urandom_range(0, 15));
        b.last = (k == len);
        beats.push_back(b);
        exp_w.push_back(b);
      end
      bresp_plan.push_back(resp);
      exp_done.push_back(resp);
    end

    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    hs = 1'b0;
    budget = 0;
    while (!hs) begin
      @(negedge clk);
      hs = cmd_ready;
      if (hs && b2b) chk("b2b_gap", 64'(cyc - last_done_cyc <= 1), 64'd1);
      @(posedge clk);
      #1;
      if (++budget > 5000) begin
        timeout_fail("cmd_accept");
        cmd_valid = 1'b0;
        return;
      end
    end
    cmd_valid = 1'b0;
    start_w = w_hs_total;

    if (rej) begin
      @(negedge clk);
      chk("reject_done", done, 1'b1);
      chk("reject_resp", done_resp, 2'b10);
      repeat (3) begin
        @(negedge clk);
        chk("reject_no_aw", awvalid, 1'b0);
      end
      return;
    end

    i = 0;
    budget = 0;
    wr_valid = 1'b0;
    while (i <= len) begin
      if (!wr_valid && (!bp || $urandom_range(0, 3) != 0)) begin
        wr_valid = 1'b1;
        wr_data  = beats[i].data;
        wr_strb  = beats[i].strb;
      end
      @(negedge clk);
      acc = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        wr_valid = 1'b0;
      end
      if (abort_after != 0 && w_hs_total - start_w >= int'(abort_after)) return;
      if (++budget > 5000) begin
        timeout_fail("user_beats");
        wr_valid = 1'b0;
        return;
      end
    end
    wr_valid = 1'b0;

    budget = 0;
    do begin
      @(negedge clk);
      if (++budget > 5000) begin
        timeout_fail("done_wait");
        return;
      end
    end while (!done);
    if (b2b) chk("ready_at_done", cmd_ready, 1'b1);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_strb   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_resp", done_resp, 2'b00);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("cmd_ready_after_reset", cmd_ready, 1'b1);

    bp = 1'b0;
    run_cmd(32'h100, 0, RESP_OKAY, 32'hDEADBEEF, 0);
    bp = 1'b1;
    run_cmd(32'h2000, 7, RESP_OKAY, $urandom, 0);
    bp = 1'b0;
    run_cmd(32'h0FF8, 3, RESP_OKAY, $urandom, 0);
    run_cmd(32'h0FF0, 3, RESP_EXOKAY, $urandom, 0);
    run_cmd(32'h1040, 3, RESP_SLVERR, $urandom, 0);

    b2b = 1'b1;
    for (int n = 0; n < 4; n++)
      run_cmd(32'h3000 + 32'(n) * 32'h40, int'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), $urandom, 0);
    b2b = 1'b0;

    bp = 1'b1;
    run_cmd(32'h5000, 255, RESP_DECERR, $urandom, 0);
    for (int n = 0; n < 25; n++) begin
      logic [31:0] a;
      int unsigned l;
      a = 32'($urandom_range(0, 15)) * 32'd4096;
      if ($urandom_range(0, 1) == 1) a = a + 32'($urandom_range(0, 1023)) * 32'd4;
      else a = a + 32'd4096 - 32'($urandom_range(1, 16)) * 32'd4;
      l = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 15);
      run_cmd(a, l, 2'($urandom_range(0, 3)), $urandom, 0);
    end

    run_cmd(32'h2400, 7, RESP_OKAY, $urandom, 2);
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("midrst_awvalid", awvalid, 1'b0);
    chk("midrst_wvalid", wvalid, 1'b0);
    chk("midrst_wlast", wlast, 1'b0);
    chk("midrst_bready", bready, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    chk("midrst_wdata", wdata, 32'h0);
    exp_aw.delete();
    exp_w.delete();
    exp_done.delete();
    bresp_plan.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_cmd(32'h3000, 5, RESP_OKAY, 32'hCAFEF00D, 0);

    repeat (4) @(negedge clk);
    chk("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    chk("w_queue_drained", 64'(exp_w.size()), 64'd0);
    chk("done_queue_drained", 64'(exp_done.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
